// File: rtl/seq_det_param.sv
// Parameterised serial pattern detector with a loadable pattern,
// optional overlapping matches and a saturating match counter.
module seq_det_param #(
  parameter int              PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
  parameter bit              OVERLAP = 1'b1,
  parameter int              CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in,
  input  logic             pat_ld,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             clr_cnt,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PAT_W-1:0] hist_n;
  logic [FW-1:0]    fill_n;
  logic             hit;

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    out_d  = 1'b0;
    cnt_d  = cnt_q;
    hist_n = {hist_q[PAT_W-2:0], in};
    fill_n = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
    hit    = 1'b0;

    if (pat_ld) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hit    = (fill_n == FULL) && (hist_n == pat_q);
      hist_d = hist_n;
      // Non-overlapping mode restarts the fill after each match
      fill_d = (hit && !OVERLAP) ? '0 : fill_n;
      out_d  = hit;
    end

    if (clr_cnt) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q  <= PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out       = out_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_det_param.sv
// Bench for seq_det_param: three parameterisations share one stimulus
// stream and are compared against a stream-history reference model.
module tb_seq_det_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, din, pat_ld, clr_cnt;
  logic [3:0] pat_in;

  logic       out_a, out_b, out_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_det_param #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .en(en), .in(din), .pat_ld(pat_ld),
    .pat_in(pat_in), .clr_cnt(clr_cnt), .out(out_a), .match_cnt(cnt_a));

  seq_det_param #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .en(en), .in(din), .pat_ld(pat_ld),
    .pat_in(pat_in), .clr_cnt(clr_cnt), .out(out_b), .match_cnt(cnt_b));

  seq_det_param #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .en(en), .in(din), .pat_ld(pat_ld),
    .pat_in(pat_in), .clr_cnt(clr_cnt), .out(out_c), .match_cnt(cnt_c));

  // Reference model: every bit sampled since reset/load, plus per-instance
  // index where the usable history starts (moved forward after a
  // non-overlapping match).
  bit       stream[$];
  int       start[3];
  bit [3:0] mpat;
  bit       mout[3];
  int       mcnt[3];
  int       cmax[3] = '{255, 255, 3};
  bit       movl[3] = '{1'b1, 1'b0, 1'b1};

  function automatic bit match_now(int i);
    int n = stream.size();
    if (n - start[i] < 4) return 1'b0;
    for (int k = 0; k < 4; k++)
      if (stream[n - 4 + k] != mpat[3 - k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, "_out_a"}, int'(out_a), int'(mout[0]));
    chk({tag, "_cnt_a"}, int'(cnt_a), mcnt[0]);
    chk({tag, "_out_b"}, int'(out_b), int'(mout[1]));
    chk({tag, "_cnt_b"}, int'(cnt_b), mcnt[1]);
    chk({tag, "_out_c"}, int'(out_c), int'(mout[2]));
    chk({tag, "_cnt_c"}, int'(cnt_c), mcnt[2]);
  endtask

  task automatic model_reset();
    stream.delete();
    mpat = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      start[i] = 0;
      mout[i]  = 1'b0;
      mcnt[i]  = 0;
    end
  endtask

  task automatic cyc(bit e, bit b, bit ld, bit [3:0] p, bit c);
    en = e; din = b; pat_ld = ld; pat_in = p; clr_cnt = c;
    @(posedge clk);
    if (ld) begin
      stream.delete();
      mpat = p;
    end else if (e) begin
      stream.push_back(b);
    end
    for (int i = 0; i < 3; i++) begin
      if (ld) start[i] = 0;
      mout[i] = !ld && e && match_now(i);
      if (mout[i] && !movl[i]) start[i] = stream.size();
      if (c) mcnt[i] = 0;
      else if (mout[i] && mcnt[i] < cmax[i]) mcnt[i]++;
    end
    #1;
    chk_all("cyc");
  endtask

  task automatic bit1(bit b);
    cyc(1'b1, b, 1'b0, 4'h0, 1'b0);
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic rst_pulse();
    @(negedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk_all("rst");
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    bit e; bit b; bit eo; int ec;
  } vec_t;
  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1};

    rst = 1'b0; en = 1'b0; din = 1'b0;
    pat_ld = 1'b0; pat_in = 4'h0; clr_cnt = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("init");
    @(negedge clk);
    rst = 1'b1;

    // Basic detection from reset
    foreach (tbl[i]) begin
      cyc(tbl[i].e, tbl[i].b, 1'b0, 4'h0, 1'b0);
      chk("tbl_out", int'(out_a), int'(tbl[i].eo));
      chk("tbl_cnt", int'(cnt_a), tbl[i].ec);
    end

    // Overlap vs non-overlap
    rst_pulse();
    bit1(1); bit1(0); bit1(1); bit1(0);
    chk("ovl_b4_a", int'(out_a), 1);
    chk("ovl_b4_b", int'(out_b), 1);
    bit1(1); bit1(0);
    chk("ovl_b6_a", int'(out_a), 1);
    chk("ovl_b6_b", int'(out_b), 0);
    chk("ovl_cnt_a", int'(cnt_a), 2);
    chk("ovl_cnt_b", int'(cnt_b), 1);

    // Gaps with en low
    rst_pulse();
    bit1(1); bit1(0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, k[0], 1'b0, 4'h0, 1'b0);
      chk("en0_out", int'(out_a), 0);
    end
    bit1(1); bit1(0);
    chk("en_gap_out", int'(out_a), 1);
    chk("en_gap_cnt", int'(cnt_a), 1);

    // Pattern load mid-stream
    rst_pulse();
    bit1(1); bit1(0); bit1(1);
    cyc(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
    chk("ld_out", int'(out_a), 0);
    chk("ld_cnt", int'(cnt_a), 0);
    bit1(0);
    chk("ld_next0", int'(out_a), 0);
    bit1(0); bit1(1); bit1(1); bit1(0);
    chk("ld_hit", int'(out_a), 1);
    chk("ld_hit_cnt", int'(cnt_a), 1);

    // Saturation and clear-vs-match priority
    rst_pulse();
    for (int k = 0; k < 6; k++) begin
      bit1(1); bit1(0);
    end
    chk("sat_cnt_c", int'(cnt_c), 3);
    chk("sat_cnt_a", int'(cnt_a), 5);
    bit1(1);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
    chk("clr_out_c", int'(out_c), 1);
    chk("clr_cnt_c", int'(cnt_c), 0);

    // Reset in the middle of a pattern
    rst_pulse();
    bit1(1); bit1(0); bit1(1);
    rst_pulse();
    bit1(0);
    chk("rst_mid0", int'(out_a), 0);
    bit1(1); bit1(0);
    chk("rst_mid_nohit", int'(out_a), 0);
    bit1(1); bit1(0);
    chk("rst_mid_hit", int'(out_a), 1);

    // Randomised traffic against the model
    rst_pulse();
    for (int k = 0; k < 400; k++) begin
      cyc($urandom_range(0, 3) != 0, 1'($urandom),
          $urandom_range(0, 29) == 0, 4'($urandom),
          $urandom_range(0, 19) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
